// File: rtl/irq_timer_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// irq_timer_ctrl_pkg : register map, TCON layout and IRQ IDs   | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package irq_timer_ctrl_pkg;

  // Register word index (addr[4:2]); byte offsets 0x00, 0x04, 0x08, 0x0C
  localparam logic [2:0] TH_OFS    = 3'd0;
  localparam logic [2:0] TL_OFS    = 3'd1;
  localparam logic [2:0] TCON_OFS  = 3'd2;
  localparam logic [2:0] IRQID_OFS = 3'd3;

  localparam int TEN   = 0;
  localparam int TIE   = 1;
  localparam int TPEND = 2;
  localparam int XIE   = 3;
  localparam int XPEND = 4;

  localparam logic [1:0] ID_NONE  = 2'd0;
  localparam logic [1:0] ID_TIMER = 2'd1;
  localparam logic [1:0] ID_EXT   = 2'd2;

  typedef struct packed {
    logic xpend;
    logic xie;
    logic tpend;
    logic tie;
    logic ten;
  } tcon_t;

  function automatic logic [1:0] irq_id(input logic tact, input logic xact);
    if (tact) return ID_TIMER;
    if (xact) return ID_EXT;
    return ID_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_timer_ctrl_reload.sv
// ----------------------------------------------------------------------------
// reload_timer : TH/TL reload counter with software write override | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module reload_timer #(
  parameter int RELOAD_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                th_we,
  input  logic                tl_we,
  input  logic [RELOAD_W-1:0] wdata,
  output logic [RELOAD_W-1:0] th,
  output logic [RELOAD_W-1:0] tl,
  output logic                ovf
);

  logic [RELOAD_W-1:0] r_th;
  logic [RELOAD_W-1:0] r_tl;

  assign th  = r_th;
  assign tl  = r_tl;
  assign ovf = en && (r_tl == '1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th <= '0;
      r_tl <= '0;
    end else begin
      if (th_we) r_th <= wdata;
      // A software TL write beats both the increment and the reload
      if (tl_we)    r_tl <= wdata;
      else if (ovf) r_tl <= r_th;
      else if (en)  r_tl <= r_tl + RELOAD_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_timer_ctrl.sv
// ----------------------------------------------------------------------------
// irq_timer_ctrl : timer + external IRQ controller on the peripheral bus | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module irq_timer_ctrl
  import irq_timer_ctrl_pkg::*;
#(
  parameter int          RELOAD_W = 32,
  parameter logic [31:0] BASE     = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        ext_req,
  input  logic        kernel,
  output logic        IRQ
);

  logic                w_sel;
  logic [2:0]          w_idx;
  logic                w_wr_th;
  logic                w_wr_tl;
  logic                w_wr_tcon;
  logic                w_ovf;
  logic                w_tact;
  logic                w_xact;
  logic [RELOAD_W-1:0] w_th;
  logic [RELOAD_W-1:0] w_tl;
  logic                unused_addr;
  tcon_t               r_tcon;

  // The window is 32 bytes wide; offsets past IRQID decode but read as zero
  assign w_sel       = (addr[31:5] == BASE[31:5]);
  assign w_idx       = addr[4:2];
  assign unused_addr = ^addr[1:0];

  assign w_wr_th   = MemWr && w_sel && (w_idx == TH_OFS);
  assign w_wr_tl   = MemWr && w_sel && (w_idx == TL_OFS);
  assign w_wr_tcon = MemWr && w_sel && (w_idx == TCON_OFS);

  reload_timer #(
    .RELOAD_W (RELOAD_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .en    (r_tcon.ten),
    .th_we (w_wr_th),
    .tl_we (w_wr_tl),
    .wdata (wdata[RELOAD_W-1:0]),
    .th    (w_th),
    .tl    (w_tl),
    .ovf   (w_ovf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tcon <= '0;
    end else begin
      if (w_wr_tcon) begin
        r_tcon.ten <= wdata[TEN];
        r_tcon.tie <= wdata[TIE];
        r_tcon.xie <= wdata[XIE];
      end
      // Hardware set wins over a write-1-clear in the same cycle
      r_tcon.tpend <= w_ovf   || (r_tcon.tpend && !(w_wr_tcon && wdata[TPEND]));
      r_tcon.xpend <= ext_req || (r_tcon.xpend && !(w_wr_tcon && wdata[XPEND]));
    end
  end

  assign w_tact = r_tcon.tpend && r_tcon.tie;
  assign w_xact = r_tcon.xpend && r_tcon.xie;
  assign IRQ    = !kernel && (w_tact || w_xact);

  always_comb begin
    rdata = '0;
    if (MemRd && w_sel) begin
      case (w_idx)
        TH_OFS:    rdata = 32'(w_th);
        TL_OFS:    rdata = 32'(w_tl);
        TCON_OFS:  rdata = 32'(r_tcon);
        IRQID_OFS: rdata = 32'(irq_id(w_tact, w_xact));
        default:   rdata = '0;
      endcase
    end
  end

endmodule

`default_nettype wire
